// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram equalizer: phase-controller state
// encoding, error phase codes and default scratchpad (m2) port widths.
package hist_eq_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 128;

  // Sequencer states; IDLE must stay at zero so reset lands there.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HIST   = 3'd1,
    ST_CDF    = 3'd2,
    ST_MAP    = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  // Phase codes, used both for err_phase and as the m2 mux select.
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HIST = 2'd1;
  localparam logic [1:0] ERR_CDF  = 2'd2;
  localparam logic [1:0] ERR_MAP  = 2'd3;

  // Map a state to the phase code of the stage it owns (NONE otherwise).
  function automatic logic [1:0] phase_of(input state_e s);
    logic [1:0] p;
    p = ERR_NONE;
    case (s)
      ST_HIST: p = ERR_HIST;
      ST_CDF:  p = ERR_CDF;
      ST_MAP:  p = ERR_MAP;
      default: p = ERR_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hist_eq_m2_mux.sv
// Combinational 3:1 scratchpad port mux. sel_i uses the phase codes; any
// other value (ERR_NONE) parks the port: addresses 0, data 0, write off.
module hist_eq_m2_mux
  import hist_eq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        sel_i,
  input  logic [ADDR_W-1:0] hist_read_addr_i,
  input  logic [ADDR_W-1:0] hist_write_addr_i,
  input  logic [DATA_W-1:0] hist_write_val_i,
  input  logic              hist_we_i,
  input  logic [ADDR_W-1:0] cdf_read_addr_i,
  input  logic [ADDR_W-1:0] cdf_write_addr_i,
  input  logic [DATA_W-1:0] cdf_write_val_i,
  input  logic              cdf_we_i,
  input  logic [ADDR_W-1:0] map_read_addr_i,
  input  logic [ADDR_W-1:0] map_write_addr_i,
  input  logic [DATA_W-1:0] map_write_val_i,
  input  logic              map_we_i,
  output logic [ADDR_W-1:0] read_addr_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [DATA_W-1:0] write_val_o,
  output logic              we_o
);

  // Route the selected stage to the scratchpad, default everything off.
  always_comb begin
    read_addr_o  = '0;
    write_addr_o = '0;
    write_val_o  = '0;
    we_o         = 1'b0;
    case (sel_i)
      ERR_HIST: begin
        read_addr_o  = hist_read_addr_i;
        write_addr_o = hist_write_addr_i;
        write_val_o  = hist_write_val_i;
        we_o         = hist_we_i;
      end
      ERR_CDF: begin
        read_addr_o  = cdf_read_addr_i;
        write_addr_o = cdf_write_addr_i;
        write_val_o  = cdf_write_val_i;
        we_o         = cdf_we_i;
      end
      ERR_MAP: begin
        read_addr_o  = map_read_addr_i;
        write_addr_o = map_write_addr_i;
        write_val_o  = map_write_val_i;
        we_o         = map_we_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hist_eq_sequencer.sv
// Histogram equalizer phase controller: runs HIST -> CDF -> MAP with level
// start/done handshakes, owns the m2 scratchpad port, and provides a
// per-phase watchdog plus a saturating run cycle counter.
//
// Handshake: a stage start is high for every cycle its phase is active and
// is decoded from the registered state only. The stage done is a level; the
// sequencer samples only the active phase's done on each rising clock edge
// and, when it is high, hands off to the next phase on that same edge (no
// gap, no overlap). Dones of inactive stages are never looked at.
module hist_eq_sequencer
  import hist_eq_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 65535
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_phase,
  output logic [31:0]       cycles_total,
  output logic [2:0]        dbg_state,
  output logic              hist_start,
  output logic              cdf_start,
  output logic              map_start,
  input  logic              hist_done,
  input  logic              cdf_done,
  input  logic              map_done,
  input  logic [ADDR_W-1:0] hist_m2ReadAddr,
  input  logic [ADDR_W-1:0] hist_m2WriteAddr,
  input  logic [DATA_W-1:0] hist_m2WriteVal,
  input  logic              hist_m2WE,
  input  logic [ADDR_W-1:0] cdf_m2ReadAddr,
  input  logic [ADDR_W-1:0] cdf_m2WriteAddr,
  input  logic [DATA_W-1:0] cdf_m2WriteVal,
  input  logic              cdf_m2WE,
  input  logic [ADDR_W-1:0] map_m2ReadAddr,
  input  logic [ADDR_W-1:0] map_m2WriteAddr,
  input  logic [DATA_W-1:0] map_m2WriteVal,
  input  logic              map_m2WE,
  output logic [ADDR_W-1:0] m2ReadAddr,
  output logic [ADDR_W-1:0] m2WriteAddr,
  output logic [DATA_W-1:0] m2WriteVal,
  output logic              m2WE,
  input  logic [DATA_W-1:0] m2ReadVal_in,
  output logic [DATA_W-1:0] m2ReadVal
);

  // The watchdog trips on the edge that would complete the TIMEOUT-th
  // cycle of a phase whose done is still low.
  localparam logic [16:0] WD_LIMIT = 17'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [16:0] wd_q, wd_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] total_q, total_d;
  logic        err_q, err_d;
  logic [1:0]  err_phase_q, err_phase_d;
  logic        phase_done;
  logic        in_phase;

  // State, watchdog, counters and error flags; all clear asynchronously.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      err_q       <= 1'b0;
      err_phase_q <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      err_q       <= err_d;
      err_phase_q <= err_phase_d;
    end
  end

  // Next-state logic: phase sequencing, watchdog and run bookkeeping.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    err_d       = err_q;
    err_phase_d = err_phase_q;
    phase_done  = 1'b0;
    in_phase    = 1'b0;

    case (state_q)
      ST_HIST: begin phase_done = hist_done; in_phase = 1'b1; end
      ST_CDF:  begin phase_done = cdf_done;  in_phase = 1'b1; end
      ST_MAP:  begin phase_done = map_done;  in_phase = 1'b1; end
      default: ;
    endcase

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_HIST;
          err_d       = 1'b0;
          err_phase_d = ERR_NONE;
          cnt_d       = '0;
          wd_d        = '0;
        end
      end
      ST_HIST, ST_CDF, ST_MAP: begin
        if (in_phase && cnt_q != 32'hFFFF_FFFF) begin
          cnt_d = cnt_q + 32'd1;
        end
        if (phase_done) begin
          wd_d = '0;
          case (state_q)
            ST_HIST: state_d = ST_CDF;
            ST_CDF:  state_d = ST_MAP;
            default: state_d = ST_FINISH;
          endcase
        end else if (wd_q >= WD_LIMIT) begin
          state_d     = ST_ERROR;
          err_d       = 1'b1;
          err_phase_d = phase_of(state_q);
          wd_d        = '0;
        end else begin
          wd_d = wd_q + 17'd1;
        end
      end
      ST_FINISH: begin
        total_d = cnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status and stage starts decode straight from the registered state.
  always_comb begin
    busy         = (state_q == ST_HIST) || (state_q == ST_CDF) || (state_q == ST_MAP);
    done         = (state_q == ST_FINISH);
    hist_start   = (state_q == ST_HIST);
    cdf_start    = (state_q == ST_CDF);
    map_start    = (state_q == ST_MAP);
    err          = err_q;
    err_phase    = err_phase_q;
    cycles_total = total_q;
    dbg_state    = state_q;
    m2ReadVal    = m2ReadVal_in;
  end

  hist_eq_m2_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_m2_mux (
    .sel_i            (phase_of(state_q)),
    .hist_read_addr_i (hist_m2ReadAddr),
    .hist_write_addr_i(hist_m2WriteAddr),
    .hist_write_val_i (hist_m2WriteVal),
    .hist_we_i        (hist_m2WE),
    .cdf_read_addr_i  (cdf_m2ReadAddr),
    .cdf_write_addr_i (cdf_m2WriteAddr),
    .cdf_write_val_i  (cdf_m2WriteVal),
    .cdf_we_i         (cdf_m2WE),
    .map_read_addr_i  (map_m2ReadAddr),
    .map_write_addr_i (map_m2WriteAddr),
    .map_write_val_i  (map_m2WriteVal),
    .map_we_i         (map_m2WE),
    .read_addr_o      (m2ReadAddr),
    .write_addr_o     (m2WriteAddr),
    .write_val_o      (m2WriteVal),
    .we_o             (m2WE)
  );

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Bench for hist_eq_sequencer. A run plan (per-phase latencies) drives the
// stage dones; expected starts, m2 routing and cycle totals follow from the
// plan. A second instance with TIMEOUT=16 exercises the watchdog.
module tb_hist_eq_sequencer;

  localparam int AW = 16;
  localparam int DW = 128;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hist_done = 1'b0, cdf_done = 1'b0, map_done = 1'b0;
  logic [AW-1:0] hist_ra = '0, hist_wa = '0, cdf_ra = '0, cdf_wa = '0, map_ra = '0, map_wa = '0;
  logic [DW-1:0] hist_wv = '0, cdf_wv = '0, map_wv = '0, rd_in = '0;
  logic hist_we = 1'b0, cdf_we = 1'b0, map_we = 1'b0;

  logic          busy, done, err, hist_start, cdf_start, map_start, m2WE;
  logic [1:0]    err_phase;
  logic [31:0]   cycles_total;
  logic [2:0]    dbg_state;
  logic [AW-1:0] m2ReadAddr, m2WriteAddr;
  logic [DW-1:0] m2WriteVal, m2ReadVal;

  logic          w_busy, w_done, w_err, w_hist_start, w_cdf_start, w_map_start, w_m2WE;
  logic [1:0]    w_err_phase;
  logic [31:0]   w_cycles_total;
  logic [2:0]    w_dbg_state;
  logic [AW-1:0] w_m2ReadAddr, w_m2WriteAddr;
  logic [DW-1:0] w_m2WriteVal, w_m2ReadVal;

  int n_tests = 0;
  int n_fail  = 0;

  hist_eq_sequencer #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .err(err), .err_phase(err_phase),
    .cycles_total(cycles_total), .dbg_state(dbg_state),
    .hist_start(hist_start), .cdf_start(cdf_start), .map_start(map_start),
    .hist_done(hist_done), .cdf_done(cdf_done), .map_done(map_done),
    .hist_m2ReadAddr(hist_ra), .hist_m2WriteAddr(hist_wa), .hist_m2WriteVal(hist_wv), .hist_m2WE(hist_we),
    .cdf_m2ReadAddr(cdf_ra), .cdf_m2WriteAddr(cdf_wa), .cdf_m2WriteVal(cdf_wv), .cdf_m2WE(cdf_we),
    .map_m2ReadAddr(map_ra), .map_m2WriteAddr(map_wa), .map_m2WriteVal(map_wv), .map_m2WE(map_we),
    .m2ReadAddr(m2ReadAddr), .m2WriteAddr(m2WriteAddr), .m2WriteVal(m2WriteVal), .m2WE(m2WE),
    .m2ReadVal_in(rd_in), .m2ReadVal(m2ReadVal)
  );

  hist_eq_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) u_wd (
    .clock(clock), .rst_n(rst_n), .start(start),
    .busy(w_busy), .done(w_done), .err(w_err), .err_phase(w_err_phase),
    .cycles_total(w_cycles_total), .dbg_state(w_dbg_state),
    .hist_start(w_hist_start), .cdf_start(w_cdf_start), .map_start(w_map_start),
    .hist_done(hist_done), .cdf_done(cdf_done), .map_done(map_done),
    .hist_m2ReadAddr(hist_ra), .hist_m2WriteAddr(hist_wa), .hist_m2WriteVal(hist_wv), .hist_m2WE(hist_we),
    .cdf_m2ReadAddr(cdf_ra), .cdf_m2WriteAddr(cdf_wa), .cdf_m2WriteVal(cdf_wv), .cdf_m2WE(cdf_we),
    .map_m2ReadAddr(map_ra), .map_m2WriteAddr(map_wa), .map_m2WriteVal(map_wv), .map_m2WE(map_we),
    .m2ReadAddr(w_m2ReadAddr), .m2WriteAddr(w_m2WriteAddr), .m2WriteVal(w_m2WriteVal), .m2WE(w_m2WE),
    .m2ReadVal_in(rd_in), .m2ReadVal(w_m2ReadVal)
  );

  // Clock: 10 ns period.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Fresh random stage-side traffic; write addresses identify the stage.
  task automatic drive_stages();
    hist_ra = AW'($urandom); cdf_ra = AW'($urandom); map_ra = AW'($urandom);
    hist_wa = 16'h0011; cdf_wa = 16'h0022; map_wa = 16'h0033;
    hist_wv = {$urandom, $urandom, $urandom, $urandom};
    cdf_wv  = {$urandom, $urandom, $urandom, $urandom};
    map_wv  = {$urandom, $urandom, $urandom, $urandom};
    hist_we = 1'($urandom_range(0, 1));
    cdf_we  = 1'($urandom_range(0, 1));
    map_we  = 1'($urandom_range(0, 1));
    rd_in   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Check the main instance against the phase the plan says is active
  // (0 = no stage owns m2) and whether this is the done cycle.
  task automatic chk_main(input string tag, input int ph, input logic exp_done);
    logic [AW-1:0] e_ra, e_wa;
    logic [DW-1:0] e_wv;
    logic          e_we;
    e_ra = '0; e_wa = '0; e_wv = '0; e_we = 1'b0;
    if (ph == 1) begin e_ra = hist_ra; e_wa = hist_wa; e_wv = hist_wv; e_we = hist_we; end
    if (ph == 2) begin e_ra = cdf_ra;  e_wa = cdf_wa;  e_wv = cdf_wv;  e_we = cdf_we;  end
    if (ph == 3) begin e_ra = map_ra;  e_wa = map_wa;  e_wv = map_wv;  e_we = map_we;  end
    chk({tag, " busy"}, busy, (ph != 0));
    chk({tag, " done"}, done, exp_done);
    chk({tag, " starts"}, {hist_start, cdf_start, map_start}, {ph == 1, ph == 2, ph == 3});
    chk({tag, " m2ReadAddr"}, m2ReadAddr, e_ra);
    chk({tag, " m2WriteAddr"}, m2WriteAddr, e_wa);
    chk({tag, " m2WriteVal"}, m2WriteVal, e_wv);
    chk({tag, " m2WE"}, m2WE, e_we);
    chk({tag, " m2ReadVal"}, m2ReadVal, rd_in);
  endtask

  // One frame on the main instance, entered from an IDLE cycle. Phase p
  // lasts lat[p] cycles; its done rises in its last cycle. Inactive dones
  // and start toggle randomly and must have no effect.
  task automatic run_frame(input string tag, input int l1, input int l2, input int l3);
    int lat[3];
    lat[0] = l1; lat[1] = l2; lat[2] = l3;
    drive_stages();
    hist_done = 1'($urandom_range(0, 1));
    cdf_done  = 1'($urandom_range(0, 1));
    map_done  = 1'($urandom_range(0, 1));
    start = 1'b1;
    #1;
    chk_main({tag, " idle"}, 0, 1'b0);
    tick();
    for (int p = 1; p <= 3; p++) begin
      for (int c = 1; c <= lat[p-1]; c++) begin
        drive_stages();
        hist_done = 1'($urandom_range(0, 1));
        cdf_done  = 1'($urandom_range(0, 1));
        map_done  = 1'($urandom_range(0, 1));
        if (p == 1) hist_done = (c == lat[0]);
        if (p == 2) cdf_done  = (c == lat[1]);
        if (p == 3) map_done  = (c == lat[2]);
        start = 1'($urandom_range(0, 1));
        #1;
        chk_main($sformatf("%s ph%0d c%0d", tag, p, c), p, 1'b0);
        tick();
      end
    end
    drive_stages();
    start = 1'($urandom_range(0, 1));
    #1;
    chk_main({tag, " finish"}, 0, 1'b1);
    tick();
    start = 1'b0;
    drive_stages();
    #1;
    chk_main({tag, " after"}, 0, 1'b0);
    chk({tag, " cycles_total"}, cycles_total, 32'(l1 + l2 + l3));
    chk({tag, " state"}, dbg_state, 3'd0);
    chk({tag, " err"}, {err, err_phase}, 3'b000);
  endtask

  initial begin
    // Reset values while rst_n is low.
    drive_stages();
    hist_we = 1'b1; cdf_we = 1'b1; map_we = 1'b1;
    hist_done = 1'b1;
    #2;
    chk_main("reset", 0, 1'b0);
    chk("reset cycles_total", cycles_total, 32'd0);
    chk("reset err", {err, err_phase}, 3'b000);
    chk("reset state", dbg_state, 3'd0);
    #20;
    rst_n = 1'b1;
    tick();

    // Nominal frame, then the minimum frame with dones high on entry.
    run_frame("nominal", 10, 20, 30);
    run_frame("minimum", 1, 1, 1);
    // Back-to-back random frames, each started the cycle after done.
    for (int r = 0; r < 6; r++) begin
      run_frame($sformatf("rand%0d", r), $urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12));
    end

    // Asynchronous reset in the middle of MAP.
    start = 1'b1; hist_done = 1'b1; tick();
    start = 1'b0; tick();
    cdf_done = 1'b1; tick();
    map_done = 1'b0; drive_stages(); map_we = 1'b1;
    #1;
    chk_main("pre-reset map", 3, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk_main("async reset", 0, 1'b0);
    chk("async reset cycles_total", cycles_total, 32'd0);
    chk("async reset state", dbg_state, 3'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset state", dbg_state, 3'd0);
    chk("post-reset busy", busy, 1'b0);

    // Watchdog on the TIMEOUT=16 instance: CDF never completes.
    cdf_done = 1'b0; map_done = 1'b0; hist_done = 1'b1;
    start = 1'b1; tick();
    start = 1'b0;
    #1;
    chk("wd hist_start", w_hist_start, 1'b1);
    tick();
    for (int c = 1; c <= 16; c++) begin
      drive_stages(); cdf_we = 1'b1;
      #1;
      chk($sformatf("wd cdf c%0d", c), {w_cdf_start, w_err}, 2'b10);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive_stages(); cdf_we = 1'b1;
      #1;
      chk($sformatf("wd err%0d", c), {w_err, w_err_phase}, 3'b110);
      chk($sformatf("wd starts%0d", c), {w_busy, w_hist_start, w_cdf_start, w_map_start}, 4'b0000);
      chk($sformatf("wd m2WE%0d", c), {w_m2WE, w_m2WriteAddr}, 17'd0);
      chk($sformatf("wd state%0d", c), w_dbg_state, 3'd5);
      tick();
    end
    start = 1'b1; tick();
    start = 1'b0;
    #1;
    chk("wd restart err", {w_err, w_err_phase}, 3'b000);
    chk("wd restart hist", {w_busy, w_hist_start, w_cdf_start}, 3'b110);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_eq_sequencer.md
# hist_eq_sequencer

Top-level phase controller for the histogram equalizer. Drives three stage engines in order (histogram count, CDF build, pixel remap) with per-phase start/done handshakes, and owns the scratchpad memory (m2) port, multiplexing it to whichever stage is active. Provides a per-phase watchdog, a run cycle counter, and one frame-level start/done handshake to the host.

## Interface
Parameters:
- ADDR_W, 16, m2 address width
- DATA_W, 128, m2 data width
- TIMEOUT, 65535, max cycles any single phase may take before error

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  host request; sampled in IDLE only
- busy  out  1  high in HIST, CDF, MAP
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky watchdog error; cleared by next accepted start
- err_phase  out  2  phase that timed out: 1=HIST, 2=CDF, 3=MAP; 0 otherwise
- cycles_total  out  32  cycles from start acceptance to done; held until next start
- hist_start, cdf_start, map_start  out  1 each  level start, high for the whole phase
- hist_done, cdf_done, map_done  in  1 each  level done from stage
- {hist,cdf,map}_m2ReadAddr, _m2WriteAddr  in  ADDR_W each  stage m2 addresses
- {hist,cdf,map}_m2WriteVal  in  DATA_W  stage write data
- {hist,cdf,map}_m2WE  in  1  stage write enable
- m2ReadAddr, m2WriteAddr  out  ADDR_W  to scratchpad
- m2WriteVal  out  DATA_W  to scratchpad
- m2WE  out  1  to scratchpad
- m2ReadVal_in  in  DATA_W; m2ReadVal  out  DATA_W broadcast to all stages unchanged

## Operation
- States: IDLE, HIST, CDF, MAP, FINISH, ERROR. Encoding: 3-bit, IDLE=0.
- IDLE: start=1 -> HIST; clear err, err_phase, cycle counter, watchdog.
- HIST: hist_start=1. hist_done=1 -> CDF. CDF: cdf_start=1; cdf_done=1 -> MAP. MAP: map_start=1; map_done=1 -> FINISH.
- FINISH: done=1 for exactly one cycle, latch cycles_total, -> IDLE.
- Watchdog: 17-bit counter, reset on every phase entry, increments each cycle in a phase. Reaching TIMEOUT while that phase's done is still low -> ERROR, err=1, err_phase set, all stage starts low.
- ERROR: m2WE forced 0. start=1 -> HIST (err cleared as in IDLE). Otherwise stay.
- Stage done is level-sensitive. Only the active phase's done is observed. Dones of inactive stages are ignored, including a stale high done.
- m2 mux: combinational, selected by the registered state. HIST/CDF/MAP route the matching stage ports. All other states drive addresses 0, WriteVal 0, m2WE 0.
- cycles_total: 32-bit counter, increments each cycle in HIST/CDF/MAP, saturates at 2^32-1.
- start while busy is ignored. No abort input; rst_n is the only abort.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, err_phase 0, cycles_total 0, all *_start 0, m2WE 0, m2 addresses and WriteVal 0.
- start sampled high in IDLE at edge N -> busy and hist_start high after edge N.
- Phase handoff: done sampled high at edge M -> previous start drops and next start rises after edge M. There is no gap cycle and no overlap.
- m2 mux latency is 0 cycles relative to state. A stage write issued on the same cycle its done rises still reaches m2. The stage's m2WE is gated off from the next cycle.
- map_done at edge M -> FINISH after M; done high for the cycle after M, then IDLE.
- Minimum run, all dones already high on entry: HIST, CDF, MAP, FINISH = 4 cycles; cycles_total = 3.
- rst_n asserted mid-run: immediate return to reset values; stage starts drop asynchronously.

## Structure
- Shared package hist_eq_pkg holds:
  - the state enum
  - the phase codes (ERR_NONE/HIST/CDF/MAP)
  - the ADDR_W/DATA_W defaults, reused by the stage engines.
- One sub-module, hist_eq_m2_mux: a purely combinational 3:1 port mux with a select input and a default-off select. The FSM, watchdog and counter stay in the top.

## Test plan
- Nominal: start pulse; stage models assert done after 10, 20, 30 phase cycles -> starts sequence with no gap or overlap, one-cycle done, cycles_total=60, err=0.
- Mux routing: each stage drives a distinct WriteAddr (0x11/0x22/0x33) with WE=1 -> m2 sees only the active stage's values; m2WE=0 in IDLE and FINISH.
- Watchdog: TIMEOUT=16, cdf_done never rises -> ERROR 16 cycles after CDF entry, err=1, err_phase=2, cdf_start=0, m2WE=0; a new start restarts at HIST with err=0.
- Stale done: hist_done held high from reset -> HIST lasts 1 cycle; early map_done during HIST is ignored.
- Start during busy is ignored; rst_n asserted in MAP -> all outputs at reset values immediately; state IDLE after release.
- Back-to-back: start asserted on the cycle after done -> second run accepted, cycles_total refreshed.
